spi_xfer_arbiter: RTL and testbench
===================================

// Module: spi_xfer_arbiter
// PURPOSE
//  Two-requester round-robin arbiter/sequencer in front of the single-byte SPI master. A granted requester
//  gets a burst of 1..2^LEN_W bytes. Per byte: hand tx byte to master, wait for rx byte, return it, insert
//  CS-high gap. Requester 0 = I2C bridge path, requester 1 = local config path.
// PARAMETERS
//  LEN_W       4     width of each req_len field; burst = req_len+1 bytes (1..16)
//  GAP_CYCLES  2     extra idle clk cycles between bytes of a burst (0 allowed = no gap state)
//  TIMEOUT     1023  max clk cycles in WAIT_RX before abort (counter width 10)
// PORTS
//  clk           in   1        system clock
//  rst           in   1        asynchronous reset, active-high
//  req           in   2        per-requester level request; sampled only in IDLE
//  req_len       in   2*LEN_W  {len1,len0}; bytes-1 per requester
//  wr_data0      in   8        next tx byte of requester 0 (FWFT, valid while granted)
//  wr_data1      in   8        next tx byte of requester 1
//  wr_pop        out  2        1-cycle strobe: granted requester's tx byte consumed
//  grant         out  2        one-hot owner of current burst, 0 when idle
//  rd_data       out  8        received byte (shared, qualified by rd_valid)
//  rd_valid      out  2        1-cycle strobe to granted requester
//  done          out  2        1-cycle strobe: burst complete
//  err           out  2        1-cycle strobe: burst aborted by timeout (no done)
//  busy          out  1        high whenever state != IDLE
//  spi_tx_data   out  8        byte to SPI master
//  spi_tx_valid  out  1        request to SPI master
//  spi_tx_ready  in   1        master accepted byte (1-cycle pulse)
//  spi_rx_data   in   8        master received byte
//  spi_rx_valid  in   1        master rx byte strobe
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, last_grant=1 (req 0 wins first tie), counters 0.
//  All outputs registered.
//  FSM IDLE -> SEND -> WAIT_RX -> (GAP -> SEND | DONE) -> IDLE; WAIT_RX timeout -> ABORT -> IDLE.
//  IDLE: req!=0 -> grant one-hot next cycle; both set -> requester != last_grant; latch len, byte_cnt=0.
//   spi_tx_valid=1 and spi_tx_data=wr_dataG same cycle grant rises (1 clk after req seen).
//  SEND: hold valid/data until spi_tx_ready=1; that cycle: valid<=0, wr_pop[G]<=1 next clk, -> WAIT_RX.
//  WAIT_RX: spi_rx_valid=1 -> rd_data<=spi_rx_data, rd_valid[G]<=1, byte_cnt++;
//   byte_cnt==len -> DONE, else GAP (GAP_CYCLES=0 -> SEND directly).
//   to_cnt counts from entry; reaching TIMEOUT -> ABORT; rx_valid and timeout same cycle -> rx wins.
//  GAP: count GAP_CYCLES clks, then SEND (tx_valid=1 on entry to SEND) with next wr_dataG.
//  DONE: done[G] 1 cycle, grant<=0, last_grant<=G, -> IDLE. ABORT: same, err[G] not done.
//  Requester holding req through done is re-eligible in IDLE next cycle; round-robin serves other first.
//  req/req_len changes during burst ignored. spi_tx_ready outside SEND ignored.
//  spi_rx_valid outside WAIT_RX ignored. rst mid-burst: outputs drop asynchronously, no done/err.
//  byte_cnt LEN_W bits; len=2^LEN_W-1 gives 16 bytes without wrap issue (compare before increment).
// TESTING
//  rst pulse mid-burst (after 2nd byte) -> tx_valid/grant 0 immediately, no done; next req works.
//  req=01 len0=0, wr_data0=A5, spi_master CLK_DIV=4 looped miso -> 1 tx A5, rd_valid=01 rd_data=A5, done=01.
//  req=11 len0=len1=1 -> grant 01 (2 bytes), done=01, then grant 10 (2 bytes), done=10.
//   Next tie -> grant 01.
//  req=10 len1=15, bytes 00..0F -> 16 wr_pop, 16 rd_valid, gaps>=GAP_CYCLES clks with tx_valid=0, one done.
//  Stub master: spi_tx_ready never -> tx_valid held indefinitely, busy=1.
//   Stub gives ready but no rx -> err=01 at TIMEOUT clks.
//  Stub: rx_valid same clk as to_cnt==TIMEOUT -> byte accepted, no err.

Source files
------------

// File: rtl/spi_xfer_arbiter.sv
// Two-requester round-robin burst sequencer in front of a single-byte SPI master.
// A granted burst moves req_len+1 bytes, one at a time, with an idle CS-high gap between bytes.
module spi_xfer_arbiter #(
    parameter int LEN_W      = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic [2*LEN_W-1:0] req_len,
    input  logic [7:0]         wr_data0,
    input  logic [7:0]         wr_data1,
    output logic [1:0]         wr_pop,
    output logic [1:0]         grant,
    output logic [7:0]         rd_data,
    output logic [1:0]         rd_valid,
    output logic [1:0]         done,
    output logic [1:0]         err,
    output logic               busy,
    output logic [7:0]         spi_tx_data,
    output logic               spi_tx_valid,
    input  logic               spi_tx_ready,
    input  logic [7:0]         spi_rx_data,
    input  logic               spi_rx_valid
);

    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_RX,
        S_GAP,
        S_DONE,
        S_ABORT
    } state_t;

    state_t           state;
    logic             owner;
    logic             last_grant;
    logic             pick;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] byte_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [7:0]       owner_data;

    // On a tie the requester that did not own the previous burst wins.
    always_comb begin
        pick = 1'b0;
        if (req == 2'b11) begin
            pick = ~last_grant;
        end else if (req[1]) begin
            pick = 1'b1;
        end
    end

    assign owner_data = owner ? wr_data1 : wr_data0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            len          <= '0;
            byte_cnt     <= '0;
            to_cnt       <= '0;
            gap_cnt      <= '0;
            wr_pop       <= 2'b00;
            grant        <= 2'b00;
            rd_data      <= 8'h00;
            rd_valid     <= 2'b00;
            done         <= 2'b00;
            err          <= 2'b00;
            busy         <= 1'b0;
            spi_tx_data  <= 8'h00;
            spi_tx_valid <= 1'b0;
        end else begin
            wr_pop   <= 2'b00;
            rd_valid <= 2'b00;
            done     <= 2'b00;
            err      <= 2'b00;
            case (state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        owner        <= pick;
                        grant        <= pick ? 2'b10 : 2'b01;
                        len          <= pick ? req_len[2*LEN_W-1 -: LEN_W] : req_len[LEN_W-1:0];
                        byte_cnt     <= '0;
                        spi_tx_data  <= pick ? wr_data1 : wr_data0;
                        spi_tx_valid <= 1'b1;
                        busy         <= 1'b1;
                        state        <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (spi_tx_ready) begin
                        spi_tx_valid <= 1'b0;
                        wr_pop       <= grant;
                        to_cnt       <= '0;
                        state        <= S_WAIT_RX;
                    end
                end
                S_WAIT_RX: begin
                    // A byte arriving on the timeout cycle still counts.
                    if (spi_rx_valid) begin
                        rd_data  <= spi_rx_data;
                        rd_valid <= grant;
                        if (byte_cnt == len) begin
                            state <= S_DONE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            if (GAP_CYCLES == 0) begin
                                spi_tx_data  <= owner_data;
                                spi_tx_valid <= 1'b1;
                                state        <= S_SEND;
                            end else begin
                                gap_cnt <= '0;
                                state   <= S_GAP;
                            end
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state <= S_ABORT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        spi_tx_data  <= owner_data;
                        spi_tx_valid <= 1'b1;
                        state        <= S_SEND;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done       <= grant;
                    grant      <= 2'b00;
                    last_grant <= owner;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                S_ABORT: begin
                    err        <= grant;
                    grant      <= 2'b00;
                    last_grant <= owner;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter: a stub SPI master and two FWFT requesters drive bursts,
// a negedge monitor scores grants, received bytes and done/err strobes against expectation queues.
module tb_spi_xfer_arbiter;
    localparam int LEN_W      = 4;
    localparam int GAP_CYCLES = 2;
    localparam int TIMEOUT    = 1023;
    localparam int READY_DLY  = 2;
    localparam int RX_DLY     = 3;
    localparam int M_NORMAL   = 0;
    localparam int M_NO_READY = 1;
    localparam int M_NO_RX    = 2;
    localparam int M_RX_LATE  = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [1:0]         req;
    logic [2*LEN_W-1:0] req_len = '0;
    logic [7:0]         wr_data0, wr_data1;
    logic [1:0]         wr_pop, grant, rd_valid, done, err;
    logic [7:0]         rd_data;
    logic               busy;
    logic [7:0]         spi_tx_data;
    logic               spi_tx_valid;
    logic               spi_tx_ready;
    logic [7:0]         spi_rx_data;
    logic               spi_rx_valid;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_grant_q[$];
    logic [9:0] exp_rd_q[$];
    logic [3:0] exp_end_q[$];

    logic [7:0] fifo0[32];
    logic [7:0] fifo1[32];
    int ptr0, ptr1;
    logic [1:0] want = 2'b00;
    int kick = 0;
    int kick_seen;
    int stub_mode = M_NORMAL;
    logic [7:0] rx_xor = 8'h5A;
    int cyc = 0;
    int pop_total = 0;
    int rd_total = 0;
    int pop_cyc = 0;
    int end_cyc = 0;

    assign wr_data0 = fifo0[ptr0[4:0]];
    assign wr_data1 = fifo1[ptr1[4:0]];

    spi_xfer_arbiter #(
        .LEN_W(LEN_W), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len),
        .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_pop(wr_pop),
        .grant(grant), .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .err(err), .busy(busy),
        .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid), .spi_tx_ready(spi_tx_ready),
        .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start(input logic [1:0] r);
        want = r;
        kick++;
    endtask

    task automatic expect_burst(input logic [1:0] g, input int nrd, input logic [3:0] end_code);
        exp_grant_q.push_back(g);
        for (int i = 0; i < nrd; i++)
            exp_rd_q.push_back({g, (g[1] ? fifo1[i] : fifo0[i]) ^ rx_xor});
        if (end_code != 4'h0) exp_end_q.push_back(end_code);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_grant_q.size() != 0 || exp_rd_q.size() != 0 || exp_end_q.size() != 0 ||
                busy || kick_seen != kick) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timed_out"}, (n >= budget) ? 1 : 0, 0);
        tick(2);
    endtask

    // Requesters: own req and the FWFT read pointers; drop req on their own done/err.
    initial begin
        req = 2'b00; ptr0 = 0; ptr1 = 0; kick_seen = 0;
        forever begin
            @(negedge clk);
            if (wr_pop[0]) ptr0++;
            if (wr_pop[1]) ptr1++;
            req = req & ~(done | err);
            if (kick_seen != kick) begin
                req = want; ptr0 = 0; ptr1 = 0; kick_seen = kick;
            end
        end
    end

    // Stub SPI master: ready after READY_DLY, rx byte RX_DLY cycles after the pop is seen.
    initial begin
        int sphase = 0;
        int scnt = 0;
        logic [7:0] scap = 8'h00;
        spi_tx_ready = 1'b0; spi_rx_valid = 1'b0; spi_rx_data = 8'h00;
        forever begin
            @(negedge clk);
            spi_tx_ready = 1'b0;
            spi_rx_valid = 1'b0;
            if (rst || !busy) begin
                sphase = 0; scnt = 0;
            end else if (sphase == 0) begin
                if (spi_tx_valid && stub_mode != M_NO_READY) begin
                    if (scnt == READY_DLY) begin
                        spi_tx_ready = 1'b1; scap = spi_tx_data; sphase = 1; scnt = 0;
                    end else scnt++;
                end
            end else if (sphase == 1) begin
                if (wr_pop != 2'b00) begin sphase = 2; scnt = 0; end
            end else begin
                scnt++;
                if (stub_mode != M_NO_RX && scnt == ((stub_mode == M_RX_LATE) ? TIMEOUT : RX_DLY)) begin
                    spi_rx_valid = 1'b1; spi_rx_data = scap ^ rx_xor; sphase = 0; scnt = 0;
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [1:0] prev_grant = 2'b00;
        int gap_len = 0;
        bit gap_run = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_grant = 2'b00; gap_run = 1'b0;
            end else begin
                if (grant != 2'b00 && prev_grant == 2'b00) begin
                    if (exp_grant_q.size() == 0) check("grant_unexpected", grant, 0);
                    else check("grant", grant, exp_grant_q.pop_front());
                end
                if (wr_pop != 2'b00) begin pop_total++; pop_cyc = cyc; end
                if (rd_valid != 2'b00) begin
                    rd_total++;
                    if (exp_rd_q.size() == 0) check("rd_unexpected", {rd_valid, rd_data}, 0);
                    else check("rd", {rd_valid, rd_data}, exp_rd_q.pop_front());
                    gap_run = 1'b1; gap_len = 0;
                end
                if (gap_run) begin
                    if (spi_tx_valid) begin
                        check("gap_min", (gap_len >= GAP_CYCLES) ? GAP_CYCLES : gap_len, GAP_CYCLES);
                        gap_run = 1'b0;
                    end else gap_len++;
                end
                if (!busy) gap_run = 1'b0;
                if ((done | err) != 2'b00) begin
                    end_cyc = cyc;
                    if (exp_end_q.size() == 0) check("end_unexpected", {done, err}, 0);
                    else check("end", {done, err}, exp_end_q.pop_front());
                end
                prev_grant = grant;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_pop, base_rd, n, d;
        for (int i = 0; i < 32; i++) begin fifo0[i] = 8'h00; fifo1[i] = 8'h00; end
        #23;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_valid", spi_tx_valid, 0);
        check("rst_strobes", {wr_pop, rd_valid, done, err}, 0);
        check("rst_data", {rd_data, spi_tx_data}, 0);
        @(negedge clk); rst = 1'b0;
        tick(2);

        // Tie from reset: requester 0 first, then 1, two bytes each.
        fifo0[0] = 8'h10; fifo0[1] = 8'h11; fifo1[0] = 8'h20; fifo1[1] = 8'h21;
        req_len = {4'd1, 4'd1};
        expect_burst(2'b01, 2, 4'b0100);
        expect_burst(2'b10, 2, 4'b1000);
        start(2'b11);
        wait_drain("tie1", 400);

        // Next tie: requester 1 was served last, so 0 wins again.
        fifo0[0] = 8'h30; fifo1[0] = 8'h40;
        req_len = {4'd0, 4'd0};
        expect_burst(2'b01, 1, 4'b0100);
        expect_burst(2'b10, 1, 4'b1000);
        start(2'b11);
        wait_drain("tie2", 400);

        // Reset during the third byte of a 4-byte burst: no done, outputs drop at once.
        fifo0[0] = 8'h50; fifo0[1] = 8'h51; fifo0[2] = 8'h52; fifo0[3] = 8'h53;
        req_len = {4'd0, 4'd3};
        expect_burst(2'b01, 2, 4'h0);
        base_rd = rd_total;
        start(2'b01);
        n = 0;
        while (rd_total < base_rd + 2 && n < 500) begin @(negedge clk); n++; end
        check("rst_mid_two_bytes", rd_total - base_rd, 2);
        n = 0;
        while (!spi_tx_valid && n < 50) begin @(negedge clk); n++; end
        check("rst_mid_third_send", spi_tx_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_tx_valid", spi_tx_valid, 0);
        check("rst_mid_grant", grant, 0);
        check("rst_mid_busy", busy, 0);
        start(2'b00);
        tick(2);
        rst = 1'b0;
        tick(3);
        check("rst_mid_queues", exp_grant_q.size() + exp_rd_q.size() + exp_end_q.size(), 0);

        // Single byte A5 with looped-back data.
        rx_xor = 8'h00;
        fifo0[0] = 8'hA5;
        req_len = {4'd0, 4'd0};
        expect_burst(2'b01, 1, 4'b0100);
        base_pop = pop_total;
        start(2'b01);
        wait_drain("a5", 400);
        check("a5_pops", pop_total - base_pop, 1);

        // Full 16-byte burst from requester 1.
        rx_xor = 8'h5A;
        for (int i = 0; i < 16; i++) fifo1[i] = 8'(i);
        req_len = {4'd15, 4'd0};
        expect_burst(2'b10, 16, 4'b1000);
        base_pop = pop_total; base_rd = rd_total;
        start(2'b10);
        wait_drain("burst16", 1000);
        check("burst16_pops", pop_total - base_pop, 16);
        check("burst16_rd", rd_total - base_rd, 16);

        // Master never ready: byte held, still busy.
        stub_mode = M_NO_READY;
        fifo0[0] = 8'h3C;
        req_len = {4'd0, 4'd0};
        expect_burst(2'b01, 0, 4'h0);
        base_pop = pop_total;
        start(2'b01);
        tick(40);
        check("noready_tx_valid", spi_tx_valid, 1);
        check("noready_tx_data", spi_tx_data, 8'h3C);
        check("noready_busy", busy, 1);
        check("noready_grant", grant, 2'b01);
        check("noready_no_pop", pop_total - base_pop, 0);
        start(2'b00);
        tick(2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        stub_mode = M_NORMAL;
        tick(2);

        // Ready but no rx: abort with err, no done.
        stub_mode = M_NO_RX;
        fifo0[0] = 8'h11;
        expect_burst(2'b01, 0, 4'b0001);
        start(2'b01);
        wait_drain("timeout", TIMEOUT + 200);
        d = end_cyc - pop_cyc;
        check("timeout_latency_in_range", (d >= TIMEOUT && d <= TIMEOUT + 2) ? 1 : 0, 1);

        // rx arrives on the very timeout cycle: byte accepted, done not err.
        stub_mode = M_RX_LATE;
        fifo0[0] = 8'h77;
        expect_burst(2'b01, 1, 4'b0100);
        start(2'b01);
        wait_drain("rx_late", TIMEOUT + 200);
        stub_mode = M_NORMAL;

        check("leftover_expectations", exp_grant_q.size() + exp_rd_q.size() + exp_end_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
